pio_debounce_irq: RTL



---
 rtl/pio_debounce_irq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pio_debounce_irq.sv
// Avalon-MM PIO: synchronised, debounced, edge-captured inputs with a maskable level IRQ,
// plus CPU-written outputs. Define PIO_DEBOUNCE_PWM_EN to add the DUTY register and global PWM dimming.
module pio_debounce_irq #(
  parameter int N_IN            = 14,
  parameter int N_OUT           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_OUT-1:0] pin_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ADDR_DATA_IN  = 3'd0,
    ADDR_DATA_OUT = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_RISE_EN  = 3'd4,
    ADDR_FALL_EN  = 3'd5,
    ADDR_DUTY     = 3'd6
  } addr_e;

  logic [N_IN-1:0]  sync1, sync2, stable;
  logic [N_IN-1:0]  accept, rise, fall;
  logic [CW-1:0]    cnt [N_IN];
  logic [N_IN-1:0]  irq_mask, edge_cap, rise_en, fall_en;
  logic [N_OUT-1:0] data_out;
  logic [N_OUT-1:0] out_gate;
  logic [31:0]      rd_val;

  // Upper write-data bits beyond the implemented register widths are intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the edge where it has differed from stable for DEBOUNCE_CYCLES samples.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_IN; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
    rise = accept & sync2;
    fall = accept & ~sync2;
  end

  // NOTE: the counter array is reset explicitly so a reset mid-debounce discards partial counts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Control registers; a capture set on the same edge as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else begin
      if (avs_write && avs_address == ADDR_DATA_OUT) data_out <= avs_writedata[N_OUT-1:0];
      if (avs_write && avs_address == ADDR_IRQ_MASK) irq_mask <= avs_writedata[N_IN-1:0];
      if (avs_write && avs_address == ADDR_RISE_EN)  rise_en  <= avs_writedata[N_IN-1:0];
      if (avs_write && avs_address == ADDR_FALL_EN)  fall_en  <= avs_writedata[N_IN-1:0];
      if (avs_write && avs_address == ADDR_EDGE_CAP)
        edge_cap <= (edge_cap & ~avs_writedata[N_IN-1:0]) | (rise & rise_en) | (fall & fall_en);
      else
        edge_cap <= edge_cap | (rise & rise_en) | (fall & fall_en);
    end
  end

`ifdef PIO_DEBOUNCE_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= 8'hFF;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (avs_write && avs_address == ADDR_DUTY) duty <= avs_writedata[7:0];
    end
  end

  assign out_gate = {N_OUT{(duty == 8'hFF) || (pwm_cnt < duty)}};
`else
  assign out_gate = '1;
`endif

  always_comb begin
    rd_val = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_val = 32'(stable);
      ADDR_DATA_OUT: rd_val = 32'(data_out);
      ADDR_IRQ_MASK: rd_val = 32'(irq_mask);
      ADDR_EDGE_CAP: rd_val = 32'(edge_cap);
      ADDR_RISE_EN:  rd_val = 32'(rise_en);
      ADDR_FALL_EN:  rd_val = 32'(fall_en);
`ifdef PIO_DEBOUNCE_PWM_EN
      ADDR_DUTY:     rd_val = 32'(duty);
`endif
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
      pin_out      <= '0;
    end else begin
      if (avs_read) avs_readdata <= rd_val;
      irq     <= |(edge_cap & irq_mask);
      pin_out <= data_out & out_gate;
    end
  end

endmodule
